slave_responder: RTL and testbench

//  Responder end of the Q/P request-response interface: accepts requests on the Q channel
//  (QVALID/QREADY), executes them against a local word memory, and returns one response per

---
 rtl/slave_pkg.sv | 16 +
 rtl/slave_rsp_fifo.sv | 65 ++++++
 rtl/slave_responder.sv | 118 +++++++++++
 tb/tb_slave_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/slave_pkg.sv
// Shared types for the Q/P responder: response codes and the packed response word.
package slave_pkg;

    localparam int SLV_DW = 32;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef struct packed {
        resp_e              resp;
        logic [SLV_DW-1:0]  data;
    } rsp_t;

endpackage

// File: rtl/slave_rsp_fifo.sv
// Show-ahead response FIFO. Indices wrap modulo DEPTH, so DEPTH need not be a
// power of two; a wrap bit per pointer separates full from empty.
module slave_rsp_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int            PW   = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic          wr_wrap;
    logic          rd_wrap;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
    assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot at the same edge, so push-on-full is fine then.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_idx];

    // Pointer advance with modulo-DEPTH wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else begin
            if (do_push) begin
                wr_idx <= (wr_idx == LAST) ? '0 : wr_idx + PW'(1);
                if (wr_idx == LAST) wr_wrap <= ~wr_wrap;
            end
            if (do_pop) begin
                rd_idx <= (rd_idx == LAST) ? '0 : rd_idx + PW'(1);
                if (rd_idx == LAST) rd_wrap <= ~rd_wrap;
            end
        end
    end

    // Storage; cleared so the head word reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_idx] <= din;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/slave_responder.sv
// Q/P responder: executes requests against a small word memory at the accept
// edge, delays the response through a fixed-latency pipeline, then queues it in
// a show-ahead FIFO. Credits bound pipeline+FIFO occupancy to RSP_DEPTH.
module slave_responder
    import slave_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 32,
    parameter int MEM_WORDS = 16,
    parameter int LAT       = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          QVALID,
    output logic          QREADY,
    input  logic          QWRITE,
    input  logic [AW-1:0] QADDR,
    input  logic [DW-1:0] QDATA,
    output logic          PVALID,
    input  logic          PREADY,
    output logic [DW-1:0] PDATA,
    output logic [1:0]    PRESP
);

    localparam int            IW      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int            CW      = $clog2(RSP_DEPTH + 1);
    localparam int            RW      = DW + 2;
    localparam logic [CW-1:0] CREDITS = CW'(RSP_DEPTH);

    logic          accept;
    logic          pop;
    logic          in_range;
    logic [IW-1:0] word_idx;
    logic [DW-1:0] mem [MEM_WORDS];
    resp_e         new_resp;
    logic [DW-1:0] new_data;
    logic [RW-1:0] new_rsp;
    logic [LAT-1:0] pipe_vld;
    logic [RW-1:0] pipe_rsp [LAT];
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [RW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_full;

    assign accept   = QVALID && QREADY;
    assign pop      = PVALID && PREADY;
    assign in_range = (int'(QADDR) < MEM_WORDS);
    assign word_idx = QADDR[IW-1:0];
    assign new_resp = in_range ? OKAY : SLVERR;
    assign new_data = (in_range && !QWRITE) ? mem[word_idx] : '0;
    assign new_rsp  = {new_resp, new_data};

    // Word memory; writes land at the accept edge so the next request sees them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (accept && QWRITE && in_range) begin
            mem[word_idx] <= QDATA;
        end
    end

    // Fixed-latency response pipeline; never stalls, credits keep the FIFO from overflowing.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pipe_vld <= '0;
            for (int i = 0; i < LAT; i++) pipe_rsp[i] <= '0;
        end else begin
            pipe_vld[0] <= accept;
            pipe_rsp[0] <= new_rsp;
            for (int i = 1; i < LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_rsp[i] <= pipe_rsp[i-1];
            end
        end
    end

    // Next outstanding count: accept and handshake in the same cycle cancel.
    always_comb begin
        outstanding_next = outstanding;
        if (accept && !pop) begin
            outstanding_next = outstanding + CW'(1);
        end else if (pop && !accept) begin
            outstanding_next = outstanding - CW'(1);
        end
    end

    // Credit counter and registered QREADY, decoupling PREADY from QREADY.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            outstanding <= '0;
            QREADY      <= 1'b0;
        end else begin
            outstanding <= outstanding_next;
            QREADY      <= (outstanding_next < CREDITS);
        end
    end

    slave_rsp_fifo #(
        .W     (RW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (pipe_vld[LAT-1]),
        .din   (pipe_rsp[LAT-1]),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign PVALID = !fifo_empty;
    assign PDATA  = fifo_dout[DW-1:0];
    assign PRESP  = fifo_dout[RW-1:DW];

endmodule

// File: tb/tb_slave_responder.sv
// Randomized and directed bench for slave_responder against a queue-based model.
module tb_slave_responder;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int MW  = 16;
    localparam int LAT = 2;
    localparam int D   = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          QVALID = 1'b0;
    logic          QREADY;
    logic          QWRITE = 1'b0;
    logic [AW-1:0] QADDR = '0;
    logic [DW-1:0] QDATA = '0;
    logic          PVALID;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PDATA;
    logic [1:0]    PRESP;

    slave_responder #(
        .AW(AW), .DW(DW), .MEM_WORDS(MW), .LAT(LAT), .RSP_DEPTH(D)
    ) dut (
        .CLK(CLK), .RST(RST),
        .QVALID(QVALID), .QREADY(QREADY), .QWRITE(QWRITE), .QADDR(QADDR), .QDATA(QDATA),
        .PVALID(PVALID), .PREADY(PREADY), .PDATA(PDATA), .PRESP(PRESP)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          avail;
    } exp_t;

    exp_t        mq[$];
    logic [31:0] mmem [MW];
    int          cyc = 0;
    bit          live = 1'b0;
    bit          exp_qready = 1'b0;
    bit          last_acc = 1'b0;
    int          dut_acc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit exp_pvalid();
        return (mq.size() > 0) && (mq[0].avail <= cyc);
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < MW; i++) mmem[i] = '0;
        live = 1'b0;
        exp_qready = 1'b0;
    endtask

    task automatic model_exec(input logic qw, input logic [7:0] qa, input logic [31:0] qd);
        exp_t e;
        e.avail = cyc + LAT;
        if (int'(qa) < MW) begin
            e.resp = 2'b00;
            if (qw) begin
                mmem[qa[3:0]] = qd;
                e.data = '0;
            end else begin
                e.data = mmem[qa[3:0]];
            end
        end else begin
            e.resp = 2'b10;
            e.data = '0;
        end
        mq.push_back(e);
    endtask

    task automatic check_outputs();
        bit pv;
        pv = exp_pvalid();
        chk("qready", QREADY, exp_qready);
        chk("pvalid", PVALID, pv);
        if (pv && PVALID) begin
            chk("pdata", PDATA, mq[0].data);
            chk("presp", PRESP, mq[0].resp);
        end
    endtask

    // One clock: drive inputs, advance the model through the edge, then check.
    task automatic step(input logic qv, input logic qw, input logic [7:0] qa,
                        input logic [31:0] qd, input logic pr);
        bit acc;
        bit pp;
        QVALID = qv; QWRITE = qw; QADDR = qa; QDATA = qd; PREADY = pr;
        acc = qv && exp_qready;
        pp  = pr && exp_pvalid();
        if (QVALID && QREADY) dut_acc++;
        @(posedge CLK);
        cyc++;
        #1;
        if (pp) void'(mq.pop_front());
        if (acc) model_exec(qw, qa, qd);
        live = 1'b1;
        exp_qready = live && (mq.size() < D);
        last_acc = acc;
        check_outputs();
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (mq.size() > 0 && g < 60) begin
            step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
            g++;
        end
        chk("drain_empty", mq.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int k;
        int n;
        int guard;
        bit have;
        logic        rw;
        logic [7:0]  ra;
        logic [31:0] rdat;

        model_reset();
        #1;
        chk("init_qready", QREADY, 0);
        chk("init_pvalid", PVALID, 0);
        chk("init_pdata", PDATA, 0);
        chk("init_presp", PRESP, 0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        chk("first_qready", QREADY, 1);

        // Write then read-after-write at the same address
        step(1'b1, 1'b1, 8'd3, 32'hDEADBEEF, 1'b1);
        step(1'b1, 1'b0, 8'd3, 32'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        chk("wr_rsp_pvalid", PVALID, 1);
        chk("wr_rsp_presp", PRESP, 2'b00);
        chk("wr_rsp_pdata", PDATA, 0);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        chk("rd_rsp_pvalid", PVALID, 1);
        chk("rd_rsp_presp", PRESP, 2'b00);
        chk("rd_rsp_pdata", PDATA, 32'hDEADBEEF);
        drain();

        // Out-of-range access leaves memory untouched
        for (int i = 0; i < MW; i++) step(1'b1, 1'b1, 8'(i), $urandom, 1'b1);
        drain();
        step(1'b1, 1'b0, 8'd16, 32'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        chk("oor_presp", PRESP, 2'b10);
        chk("oor_pdata", PDATA, 0);
        step(1'b1, 1'b1, 8'd200, 32'h12345678, 1'b1);
        for (int i = 0; i < MW; i++) step(1'b1, 1'b0, 8'(i), 32'd0, 1'b1);
        drain();

        // Backpressure: credits cap acceptance at D
        base = dut_acc;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            if (k < 6) begin
                step(1'b1, 1'b0, 8'(k), 32'd0, 1'b0);
                if (last_acc) k++;
            end else begin
                step(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
            end
        end
        chk("bp_accepted", dut_acc - base, 4);
        chk("bp_qready_low", QREADY, 0);
        for (int i = 0; i < 30; i++) begin
            if (k < 6) begin
                step(1'b1, 1'b0, 8'(k), 32'd0, 1'b1);
                if (last_acc) k++;
            end else begin
                step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
            end
        end
        chk("bp_total", dut_acc - base, 6);
        drain();

        // Accept and pop in the same cycle at D-1 outstanding
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i + 4), 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'd0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 8'd9, 32'd0, 1'b1);
        chk("same_cyc_qready", QREADY, 1);
        step(1'b1, 1'b0, 8'd10, 32'd0, 1'b1);
        chk("same_cyc_qready2", QREADY, 1);
        drain();

        // Reset mid-burst with 3 outstanding
        step(1'b1, 1'b1, 8'd5, 32'hCAFEF00D, 1'b0);
        step(1'b1, 1'b0, 8'd5, 32'd0, 1'b0);
        step(1'b1, 1'b0, 8'd6, 32'd0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        chk("rst_qready", QREADY, 0);
        chk("rst_pvalid", PVALID, 0);
        chk("rst_pdata", PDATA, 0);
        chk("rst_presp", PRESP, 0);
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_hold_qready", QREADY, 0);
        chk("rst_hold_pvalid", PVALID, 0);
        @(negedge CLK);
        RST = 1'b0;
        step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        chk("rst_rel_qready", QREADY, 1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'd0, 32'd0, 1'b1);
        step(1'b1, 1'b0, 8'd5, 32'd0, 1'b1);
        step(1'b1, 1'b0, 8'd3, 32'd0, 1'b1);
        drain();

        // Random streaming
        n = 0;
        guard = 0;
        have = 1'b0;
        rw = 1'b0; ra = '0; rdat = '0;
        while (n < 1000 && guard < 20000) begin
            if (!have) begin
                rw   = 1'($urandom_range(0, 1));
                ra   = 8'($urandom_range(0, 19));
                rdat = $urandom;
                have = 1'b1;
            end
            step(1'($urandom_range(0, 3) != 0), rw, ra, rdat, 1'($urandom_range(0, 3) != 0));
            if (last_acc) begin
                n++;
                have = 1'b0;
            end
            guard++;
        end
        chk("rand_count", n, 1000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
